life_step_engine: RTL and testbench
===================================

// Module: life_step_engine
// PURPOSE
//  Datapath responder to the life control FSM: consumes ldX/ldY/draw, owns the cell grid.
//  Seeds cells from data_in and computes one Game-of-Life generation (B3/S23, toroidal)
//  per draw request, emitting one VGA plot per cell. Returns a one-cycle stop pulse when done.
// PARAMETERS
//  GRID_W    8      cells per row; power of two, 2..128
//  GRID_H    8      cells per column; power of two, 2..128
//  X_BITS    3      $clog2(GRID_W)
//  Y_BITS    3      $clog2(GRID_H)
//  ALIVE_COL 3'b010 plot_colour for a live cell; dead cells use 3'b000
// PORTS
//  clock       in   1       single clock; all state on posedge
//  reset       in   1       asynchronous, active-high; clears all state
//  data_in     in   8       coordinate source; low X_BITS/Y_BITS bits used
//  ldX         in   1       latch x_reg <= data_in[X_BITS-1:0]
//  ldY         in   1       latch y_reg, toggle cell (x_reg, y_reg)
//  draw        in   1       level request: run one generation
//  stop        out  1       one-cycle pulse: generation committed
//  busy        out  1       high in SEED_PLOT, SCAN, COMMIT, DONE
//  plot        out  1       VGA write enable, one pixel per cycle
//  plot_x      out  X_BITS  pixel column
//  plot_y      out  Y_BITS  pixel row
//  plot_colour out  3       ALIVE_COL or 3'b000
// BEHAVIOUR
//  Reset: state=IDLE, grid/next_grid all 0, x_reg=y_reg=0, every output 0.
//  Outputs are registered/Moore; no combinational input->output path.
//  IDLE: ldX -> latch x_reg (stay). ldY -> latch y_reg, toggle grid bit, go SEED_PLOT.
//    ldX and ldY in same cycle: only X latched, ldY ignored. draw=1 (no ld) -> SCAN, idx=0.
//    Priority in IDLE: ldX > ldY > draw.
//  SEED_PLOT (1 cycle): plot=1, coordinates of the toggled cell, colour = new value -> IDLE.
//  SCAN: idx walks 0..W*H-1 row-major (x=idx[X_BITS-1:0], y=idx>>X_BITS), one cell/cycle.
//    Neighbour count 0..8 (4-bit) over 8 neighbours of the CURRENT grid, coordinates
//    wrapping mod GRID_W/GRID_H. next = (cnt==3) | (alive & cnt==2); written to next_grid.
//    plot=1 each SCAN cycle, plot_x/plot_y = cell, colour per next value.
//    After idx=W*H-1 -> COMMIT. ld*/draw ignored; a draw drop mid-scan does not abort.
//  COMMIT (1 cycle): grid <= next_grid; plot=0 -> DONE.
//  DONE (1 cycle): stop=1 -> WAIT_REL.
//  WAIT_REL: stay until draw==0, then IDLE (a held draw never starts a 2nd generation).
//  Latency: draw seen in IDLE at edge k -> plots k+1..k+W*H, stop high in cycle k+W*H+2.
//  Reset mid-operation: immediate abort to reset state; no stop pulse; grid lost.
// STRUCTURE
//  life_pkg: state enum {IDLE,SEED_PLOT,SCAN,COMMIT,DONE,WAIT_REL}, RULE_BIRTH=3,
//    RULE_SURV_LO=2, RULE_SURV_HI=3, COL_DEAD=3'b000.
//  Sub-module life_neighbour_count: combinational (grid, x, y) -> 4-bit count with wrap.
//  Top: FSM, idx counter, x_reg/y_reg, grid + next_grid flat vectors (GRID_W*GRID_H bits).
// TESTING (8x8 defaults)
//  Blinker seed (2,1),(2,2),(2,3); draw 1 -> 64 plots, live at (1,2),(2,2),(3,2) only;
//    stop exactly 1 cycle, 66 cycles after draw sampled; second draw restores vertical.
//  Wrap: seed (0,0),(7,0),(0,7),(7,7) (toroidal block) -> unchanged after 3 generations.
//  Toggle: ldX=5, ldY=5 twice -> two SEED_PLOT pulses, colours 3'b010 then 3'b000; grid empty.
//  Held draw: draw high 200 cycles -> exactly one stop pulse and 64 scan plots, no restart.
//  Reset at SCAN idx 20 -> all outputs 0 next cycle, no stop, next draw plots all dead.
//  ldX and ldY together with data_in=6 -> x_reg=6, y_reg unchanged, no plot.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and Game-of-Life rule constants for the life step engine.
package life_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED_PLOT,
        SCAN,
        COMMIT,
        DONE,
        WAIT_REL
    } life_state_e;

    localparam logic [3:0] RULE_BIRTH   = 4'd3;
    localparam logic [3:0] RULE_SURV_LO = 4'd2;
    localparam logic [3:0] RULE_SURV_HI = 4'd3;
    localparam logic [2:0] COL_DEAD     = 3'b000;

    // B3/S23: birth on exactly three neighbours, survival on two or three.
    function automatic logic next_alive(input logic alive, input logic [3:0] cnt);
        return (cnt == RULE_BIRTH) ||
               (alive && (cnt >= RULE_SURV_LO) && (cnt <= RULE_SURV_HI));
    endfunction

endpackage

// File: rtl/life_neighbour_count.sv
// Counts the live neighbours of one cell on a toroidal grid (purely combinational).
module life_neighbour_count #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int X_BITS = 3,
    parameter int Y_BITS = 3
) (
    input  logic [GRID_W*GRID_H-1:0] grid,
    input  logic [X_BITS-1:0]        x,
    input  logic [Y_BITS-1:0]        y,
    output logic [3:0]               count
);

    logic [X_BITS-1:0] xs [3];
    logic [Y_BITS-1:0] ys [3];

    // Power-of-two dimensions let plain modular add/subtract provide the wrap.
    always_comb begin
        xs[0] = x - X_BITS'(1);
        xs[1] = x;
        xs[2] = x + X_BITS'(1);
        ys[0] = y - Y_BITS'(1);
        ys[1] = y;
        ys[2] = y + Y_BITS'(1);
        count = '0;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(i == 1 && j == 1)) begin
                    count = count + {3'b000, grid[{ys[j], xs[i]}]};
                end
            end
        end
    end

endmodule

// File: rtl/life_step_engine.sv
// Game-of-Life datapath: seeds the cell grid from the control FSM and runs one
// toroidal generation per draw request, plotting every cell to the VGA port.
module life_step_engine
    import life_pkg::*;
#(
    parameter int         GRID_W    = 8,
    parameter int         GRID_H    = 8,
    parameter int         X_BITS    = 3,
    parameter int         Y_BITS    = 3,
    parameter logic [2:0] ALIVE_COL = 3'b010
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        data_in,
    input  logic              ldX,
    input  logic              ldY,
    input  logic              draw,
    output logic              stop,
    output logic              busy,
    output logic              plot,
    output logic [X_BITS-1:0] plot_x,
    output logic [Y_BITS-1:0] plot_y,
    output logic [2:0]        plot_colour
);

    localparam int CELLS    = GRID_W * GRID_H;
    localparam int IDX_BITS = X_BITS + Y_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(CELLS - 1);

    life_state_e state, next_state;

    logic [IDX_BITS-1:0] idx;
    logic [X_BITS-1:0]   x_reg;
    logic [Y_BITS-1:0]   y_reg;
    logic [CELLS-1:0]    grid;
    logic [CELLS-1:0]    next_grid;

    logic [X_BITS-1:0]   scan_x;
    logic [Y_BITS-1:0]   scan_y;
    logic [X_BITS-1:0]   ld_x;
    logic [Y_BITS-1:0]   ld_y;
    logic [3:0]          count;
    logic                next_val;
    logic                data_unused;

    assign scan_x      = idx[X_BITS-1:0];
    assign scan_y      = idx[IDX_BITS-1:X_BITS];
    assign ld_x        = data_in[X_BITS-1:0];
    assign ld_y        = data_in[Y_BITS-1:0];
    assign data_unused = ^data_in;

    life_neighbour_count #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_count (
        .grid  (grid),
        .x     (scan_x),
        .y     (scan_y),
        .count (count)
    );

    assign next_val = next_alive(grid[idx], count);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Cells are evaluated against the current grid; next_grid only becomes
    // visible at COMMIT so the whole generation sees a consistent snapshot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            grid      <= '0;
            next_grid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ldX) begin
                        x_reg <= ld_x;
                    end else if (ldY) begin
                        y_reg                <= ld_y;
                        grid[{ld_y, x_reg}]  <= ~grid[{ld_y, x_reg}];
                    end else if (draw) begin
                        idx <= '0;
                    end
                end
                SCAN: begin
                    next_grid[idx] <= next_val;
                    idx            <= idx + IDX_BITS'(1);
                end
                COMMIT: begin
                    grid <= next_grid;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        next_state  = state;
        stop        = 1'b0;
        busy        = 1'b0;
        plot        = 1'b0;
        plot_x      = '0;
        plot_y      = '0;
        plot_colour = COL_DEAD;
        case (state)
            IDLE: begin
                if (ldX) begin
                    next_state = IDLE;
                end else if (ldY) begin
                    next_state = SEED_PLOT;
                end else if (draw) begin
                    next_state = SCAN;
                end
            end
            SEED_PLOT: begin
                busy        = 1'b1;
                plot        = 1'b1;
                plot_x      = x_reg;
                plot_y      = y_reg;
                plot_colour = grid[{y_reg, x_reg}] ? ALIVE_COL : COL_DEAD;
                next_state  = IDLE;
            end
            SCAN: begin
                busy        = 1'b1;
                plot        = 1'b1;
                plot_x      = scan_x;
                plot_y      = scan_y;
                plot_colour = next_val ? ALIVE_COL : COL_DEAD;
                if (idx == LAST_IDX) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                stop       = 1'b1;
                next_state = WAIT_REL;
            end
            WAIT_REL: begin
                if (!draw) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_life_step_engine.sv
// Directed bench for life_step_engine: a software grid model feeds a plot scoreboard.
module tb_life_step_engine;

    localparam int W = 8;
    localparam int H = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       ldX, ldY, draw;
    logic       stop, busy, plot;
    logic [2:0] plot_x, plot_y, plot_colour;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] exp_q [$];
    bit         model      [H][W];
    bit         model_next [H][W];
    int         mx;

    always #5 clock = ~clock;

    life_step_engine dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .ldX         (ldX),
        .ldY         (ldY),
        .draw        (draw),
        .stop        (stop),
        .busy        (busy),
        .plot        (plot),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge: consumes one scoreboard entry if the DUT is plotting.
    task automatic sample_plot(input string tag);
        logic [8:0] e;
        if (plot) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected_plot"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check(tag, {23'd0, plot_x, plot_y, plot_colour}, {23'd0, e});
            end
        end
    endtask

    task automatic compute_next();
        int n;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (!(dx == 0 && dy == 0)) begin
                            n += int'(model[(y + dy + H) % H][(x + dx + W) % W]);
                        end
                    end
                end
                model_next[y][x] = (n == 3) || (model[y][x] && n == 2);
                exp_q.push_back({3'(x), 3'(y), model_next[y][x] ? 3'b010 : 3'b000});
            end
        end
    endtask

    task automatic do_ldx(input int v);
        data_in = 8'(v);
        ldX     = 1'b1;
        @(posedge clock); #1;
        ldX = 1'b0;
        mx  = v;
    endtask

    task automatic do_ldy(input int v);
        model[v][mx] = ~model[v][mx];
        exp_q.push_back({3'(mx), 3'(v), model[v][mx] ? 3'b010 : 3'b000});
        data_in = 8'(v);
        ldY     = 1'b1;
        @(posedge clock); #1;
        ldY = 1'b0;
        @(negedge clock);
        check("seed_plot_en", {31'd0, plot}, 32'd1);
        sample_plot("seed_plot");
        @(negedge clock);
        check("seed_plot_one_cycle", {31'd0, plot}, 32'd0);
    endtask

    // Runs one generation; hold > 0 keeps draw high for that many cycles.
    task automatic run_generation(input string tag, input int hold);
        int plots, stops, stop_at;
        compute_next();
        plots = 0; stops = 0; stop_at = -1;
        draw = 1'b1;
        @(posedge clock); #1;
        if (hold == 0) draw = 1'b0;
        for (int c = 1; c <= 72 + hold; c++) begin
            @(negedge clock);
            if (c == 1) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (plot) plots++;
            sample_plot({tag, "_cell"});
            if (stop) begin
                stops++;
                stop_at = c;
            end
            if (c == hold) draw = 1'b0;
        end
        check({tag, "_plot_count"}, 32'(plots), 32'd64);
        check({tag, "_stop_count"}, 32'(stops), 32'd1);
        check({tag, "_stop_latency"}, 32'(stop_at), 32'd66);
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        model = model_next;
    endtask

    initial begin
        int strays;
        reset = 1'b1; data_in = '0; ldX = 0; ldY = 0; draw = 0; mx = 0;
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) model[y][x] = 1'b0;
        @(negedge clock);
        check("reset_plot", {31'd0, plot}, 32'd0);
        check("reset_stop", {31'd0, stop}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_coords", {26'd0, plot_x, plot_y}, 32'd0);
        check("reset_colour", {29'd0, plot_colour}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Toggle the same cell twice: live then dead
        do_ldx(5);
        do_ldy(5);
        do_ldy(5);

        // ldX and ldY together: only X is taken, no seed plot
        data_in = 8'd6; ldX = 1'b1; ldY = 1'b1;
        @(posedge clock); #1;
        ldX = 1'b0; ldY = 1'b0; mx = 6;
        @(negedge clock);
        check("ldxy_no_plot", {31'd0, plot}, 32'd0);
        check("ldxy_not_busy", {31'd0, busy}, 32'd0);
        do_ldy(1);
        do_ldy(1);

        // Blinker
        do_ldx(2);
        do_ldy(1);
        do_ldy(2);
        do_ldy(3);
        run_generation("blinker_gen1", 0);
        run_generation("blinker_gen2", 0);
        run_generation("held_draw", 200);

        // Reset during scan at idx 20
        compute_next();
        draw = 1'b1;
        @(posedge clock); #1;
        draw = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clock);
            sample_plot("abort_cell");
        end
        reset = 1'b1;
        @(negedge clock);
        check("abort_plot", {31'd0, plot}, 32'd0);
        check("abort_stop", {31'd0, stop}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_outputs", {23'd0, plot_x, plot_y, plot_colour}, 32'd0);
        exp_q.delete();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) model[y][x] = 1'b0;
        mx = 0;
        reset = 1'b0;
        strays = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (stop || plot) strays++;
        end
        check("abort_no_stop_or_plot", 32'(strays), 32'd0);
        run_generation("after_abort", 0);

        // Toroidal block across the four corners
        do_ldx(0);
        do_ldy(0);
        do_ldy(7);
        do_ldx(7);
        do_ldy(0);
        do_ldy(7);
        run_generation("wrap_gen1", 0);
        run_generation("wrap_gen2", 0);
        run_generation("wrap_gen3", 0);
        check("wrap_corner_model", {28'd0, model[0][0], model[0][7], model[7][0], model[7][7]}, 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
